// File: rtl/alu_arb_pkg.sv
// Shared types and opcode constants for alu_arbiter (see ALU_ARB_FIXED_PRIO_EN in the top).
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  function automatic logic op_supported(input logic [3:0] ctl);
    logic ok;
    ok = 1'b0;
    case (ctl)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority grant: the search starts at ptr and wraps around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates NREQ requesters onto one shared combinational ALU, one transaction at a time.
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_op1,
  input  logic [NREQ*DW-1:0]   req_op2,
  input  logic [NREQ*4-1:0]    req_ctl,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [DW-1:0]        rsp_result,
  output logic                 rsp_err,
  output logic [DW-1:0]        alu_op1,
  output logic [DW-1:0]        alu_op2,
  output logic [3:0]           alu_ctl,
  input  logic [DW-1:0]        alu_result
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nxt;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   win_idx;
  logic            accept;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) win_idx = PW'(i);
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // req_ready is gated by rst so it reads 0 while reset is held, even with requests pending.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rst && (|grant)) begin
          req_ready = grant;
          accept    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_ctl    <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        owner   <= win_idx;
        alu_op1 <= req_op1[win_idx*DW +: DW];
        alu_op2 <= req_op2[win_idx*DW +: DW];
        alu_ctl <= req_ctl[win_idx*4 +: 4];
      end
      if (state == ST_EXEC) begin
        rsp_result <= op_supported(alu_ctl) ? alu_result : '0;
        rsp_err    <= !op_supported(alu_ctl);
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU; honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_op1;
  logic [127:0] req_op2;
  logic [15:0]  req_ctl;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [31:0]  rsp_result;
  logic         rsp_err;
  logic [31:0]  alu_op1;
  logic [31:0]  alu_op2;
  logic [3:0]   alu_ctl;
  logic [31:0]  alu_result;

  alu_arbiter #(
    .DW   (32),
    .NREQ (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_ctl    (req_ctl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_ctl    (alu_ctl),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unsupported opcodes produce a nonzero value so that zeroing by the DUT is observable.
  always_comb begin
    case (alu_ctl)
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      4'b0111: alu_result = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
      4'b1100: alu_result = ~(alu_op1 | alu_op2);
      default: alu_result = alu_op1 ^ alu_op2 ^ 32'hdead_beef;
    endcase
  end

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        err;
  } exp_t;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [31:0] r;
    logic        e;
    bit          poke;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    req_op1[idx*32 +: 32] = a;
    req_op2[idx*32 +: 32] = b;
    req_ctl[idx*4 +: 4]   = c;
  endtask

  task automatic push(input int idx, input logic [31:0] r, input logic e);
    exp_t x;
    x.idx = idx;
    x.res = r;
    x.err = e;
    sb.push_back(x);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL wait_idle: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Response monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid != 4'b0000) begin
      chk("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
      if ((rsp_valid & rsp_ready) != 4'b0000) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got rsp_valid %b expected none", rsp_valid);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("rsp_owner", 32'(rsp_valid), 32'(4'b0001 << x.idx));
          chk("rsp_result", rsp_result, x.res);
          chk("rsp_err", 32'(rsp_err), 32'(x.err));
        end
      end
    end
  end

  task automatic send(input vec_t v);
    @(posedge clk); #1;
    set_req(v.idx, v.a, v.b, v.c);
    req_valid[v.idx] = 1'b1;
    push(v.idx, v.r, v.e);
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'(4'b0001 << v.idx));
    @(posedge clk); #1;
    req_valid[v.idx] = 1'b0;
    if (v.poke) req_valid[3] = 1'b1;
    @(negedge clk);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("alu_op1", alu_op1, v.a);
    chk("alu_op2", alu_op2, v.b);
    chk("alu_ctl", 32'(alu_ctl), 32'(v.c));
    if (v.poke) chk("busy_ready_exec", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("resp_latency", 32'(rsp_valid), 32'(4'b0001 << v.idx));
    if (v.poke) begin
      chk("busy_ready_resp", 32'(req_ready), 32'd0);
      req_valid[3] = 1'b0;
    end
    wait_idle();
  endtask

  vec_t vt[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2, 32'd5,          32'd3,          4'b0010, 32'd8,          1'b0, 1'b0};
    vt[1] = '{3, 32'd20,         32'd7,          4'b0110, 32'd13,         1'b0, 1'b0};
    vt[2] = '{0, 32'hF0F0_1234,  32'h0FF0_FF00,  4'b0000, 32'h00F0_1200,  1'b0, 1'b0};
    vt[3] = '{1, 32'h1200_0001,  32'h0034_0010,  4'b0001, 32'h1234_0011,  1'b0, 1'b1};
    vt[4] = '{2, 32'hFFFF_FFFF,  32'd1,          4'b0111, 32'd1,          1'b0, 1'b0};
    vt[5] = '{3, 32'd5,          32'd3,          4'b0111, 32'd0,          1'b0, 1'b0};
    vt[6] = '{0, 32'h0000_FFFF,  32'h00FF_0000,  4'b1100, 32'hFF00_0000,  1'b0, 1'b0};
    vt[7] = '{1, 32'd9,          32'd9,          4'b0011, 32'd0,          1'b1, 1'b0};
    vt[8] = '{0, 32'd3,          32'd5,          4'b0110, 32'hFFFF_FFFE,  1'b0, 1'b0};

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 4'b1111;
    req_op1   = '0;
    req_op2   = '0;
    req_ctl   = '0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_alu_op1", alu_op1, 32'd0);
    chk("rst_alu_op2", alu_op2, 32'd0);
    chk("rst_alu_ctl", 32'(alu_ctl), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);

`ifdef ALU_ARB_FIXED_PRIO_EN
    #1;
    set_req(0, 32'd1, 32'd1, 4'b0010);
    set_req(3, 32'd3, 32'd3, 4'b0010);
    req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) push(0, 32'd2, 1'b0);
    @(negedge clk);
    chk("fixed_first_grant", 32'(req_ready), 32'd1);
    repeat (7) @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();
`else
    #1;
    for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1), 32'd10, 4'b0010);
    req_valid = 4'b1111;
    push(0, 32'd11, 1'b0);
    push(1, 32'd12, 1'b0);
    push(2, 32'd13, 1'b0);
    push(3, 32'd14, 1'b0);
    push(0, 32'd11, 1'b0);
    @(negedge clk);
    chk("rr_first_grant", 32'(req_ready), 32'd1);
    repeat (13) @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();
`endif

    for (int i = 0; i < 9; i++) send(vt[i]);

    // Backpressure on requester 1 while requester 0 waits; non-owner rsp_ready bits are set.
    @(posedge clk); #1;
    set_req(1, 32'd7, 32'd9, 4'b0010);
    req_valid[1] = 1'b1;
    rsp_ready    = 4'b1101;
    push(1, 32'd16, 1'b0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_req(0, 32'd100, 32'd1, 4'b0010);
    req_valid[0] = 1'b1;
    push(0, 32'd101, 1'b0);
    @(negedge clk);
    chk("bp_exec_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'b0010);
      chk("bp_hold_result", rsp_result, 32'd16);
      chk("bp_hold_err", 32'(rsp_err), 32'd0);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    chk("bp_done_valid", 32'(rsp_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_idle();

    // Reset while a transaction is in EXEC; a request pending across release is taken at once.
    @(posedge clk); #1;
    set_req(3, 32'd1, 32'd2, 4'b0010);
    req_valid[3] = 1'b1;
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rexec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rexec_rsp_result", rsp_result, 32'd0);
    chk("rexec_rsp_err", 32'(rsp_err), 32'd0);
    chk("rexec_alu_op1", alu_op1, 32'd0);
    chk("rexec_alu_op2", alu_op2, 32'd0);
    chk("rexec_alu_ctl", 32'(alu_ctl), 32'd0);
    set_req(2, 32'd40, 32'd2, 4'b0010);
    req_valid[2] = 1'b1;
    push(2, 32'd42, 1'b0);
    #1;
    chk("rexec_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("release_exec", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("release_resp", 32'(rsp_valid), 32'b0100);
    wait_idle();
    repeat (5) begin
      @(negedge clk);
      chk("no_stray_rsp", 32'(rsp_valid), 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, operand/result width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have: req_valid  in  NREQ  per-requester request valid.
REQ-006 SHALL have: req_ready  out  NREQ  one-hot accept, requester i at bit i.
REQ-007 SHALL have: req_op1, req_op2  in  NREQ*DW  operands, requester i at slice [i*DW +: DW].
REQ-008 SHALL have: req_ctl  in  NREQ*4  4-bit ALU opcode per requester.
REQ-009 SHALL have: rsp_valid  out  NREQ  one-hot response valid to the owning requester.
REQ-010 SHALL have: rsp_ready  in  NREQ  per-requester response accept.
REQ-011 SHALL have: rsp_result  out  DW; rsp_err  out  1  unsupported opcode flag.
REQ-012 SHALL have: alu_op1, alu_op2  out  DW; alu_ctl  out  4  drive to the shared combinational ALU.
REQ-013 SHALL have: alu_result  in  DW  result from the shared ALU.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other states.
REQ-015 IDLE: if any req_valid, SHALL assert req_ready for exactly one winner; otherwise req_ready = 0.
REQ-016 req_ready SHALL be asserted only in IDLE, so at most one transfer per 3 cycles.
REQ-017 On accept (cycle N), SHALL register winner index, operands and opcode into alu_op1/alu_op2/alu_ctl, then enter EXEC.
REQ-018 EXEC (cycle N+1): SHALL capture alu_result into rsp_result, then enter RESP.
REQ-019 RESP (from cycle N+2): SHALL assert rsp_valid[owner] and hold rsp_result/rsp_err stable until rsp_ready[owner] = 1; then enter IDLE.
REQ-020 rsp_ready bits of non-owners SHALL be ignored.
REQ-021 Supported opcodes SHALL be 0000, 0001, 0010, 0110, 0111, 1100.
REQ-022 Any other opcode SHALL yield rsp_result = 0 and rsp_err = 1, ignoring alu_result; otherwise rsp_err = 0.
REQ-023 Round-robin: after accepting requester k, highest priority SHALL pass to (k+1) mod NREQ.
REQ-024 Round-robin pointer SHALL change only on accept, never while idle with no requests.
REQ-025 A request whose req_valid deasserts before acceptance SHALL be dropped without side effects.
REQ-026 alu_op1/alu_op2/alu_ctl SHALL hold their last values outside EXEC.

Reset
REQ-027 Asynchronous rst SHALL force state IDLE, pointer 0, and req_ready, rsp_valid, rsp_result, rsp_err, alu_op1, alu_op2, alu_ctl all to 0.
REQ-028 Reset during EXEC or RESP SHALL discard the transaction; no rsp_valid after release.
REQ-029 First accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN defined: grant SHALL go to the lowest-index valid requester; pointer logic removed.
REQ-031 Macro undefined (default): round-robin per REQ-023/024.

Structure
REQ-032 Shared package alu_arb_pkg SHALL hold the FSM state encoding and the opcode constants (AND, OR, ADD, SUB, SLT, NOR).
REQ-033 Grant selection SHALL live in sub-module rr_arbiter: request vector and pointer in, one-hot grant out, combinational.

Verification
REQ-034 Single request: requester 2 sends op1=5, op2=3, ctl=0010 -> rsp_valid[2] 2 cycles after accept, rsp_result=8, rsp_err=0.
REQ-035 Round-robin: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0.
REQ-036 Backpressure: rsp_ready[1]=0 for 5 cycles on ADD 7+9 -> rsp_result=16 held stable, req_ready=0 throughout; completes the cycle after rsp_ready[1]=1.
REQ-037 Bad opcode: ctl=0011 -> rsp_result=0, rsp_err=1.
REQ-038 Reset in EXEC: rst pulsed during EXEC -> all outputs 0, no rsp_valid afterwards, next request served normally.
REQ-039 With ALU_ARB_FIXED_PRIO_EN: requesters 0 and 3 both continuously valid -> requester 0 granted every time.
